// File: rtl/qspi_ram_pkg.sv
// Shared types and constants for the QPI RAM responder.
package qspi_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } qspi_state_e;

    localparam logic [7:0] QSPI_CMD_READ  = 8'h03;
    localparam logic [7:0] QSPI_CMD_WRITE = 8'h02;
    localparam int         ADDR_NIBBLES   = 6;

endpackage

// File: rtl/qspi_ram_array.sv
// Single-port synchronous byte RAM with one-cycle read latency (block-RAM friendly).
module qspi_ram_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [7:0]           wdata_i,
    output logic [7:0]           rdata_o
);

    logic [7:0] mem_q [2**ADDR_BITS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/qspi_ram_target.sv
// QPI RAM responder: synchronizes the initiator's SCLK/CSn/IO onto clk, decodes
// cmd/addr nibbles and serves byte reads/writes from an internal array.
module qspi_ram_target
    import qspi_ram_pkg::*;
#(
    parameter int ADDR_BITS    = 10,
    parameter int DUMMY_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic [3:0] spi_io_in,
    output logic [3:0] spi_io_out,
    output logic [3:0] spi_io_oe,
    output logic       busy
);

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

    logic                 csn_s1_q, csn_s2_q;
    logic                 sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic [3:0]           io_s1_q, io_s2_q;
    logic                 sclk_rise, sclk_fall;

    qspi_state_e          state_q, state_d;
    logic [2:0]           nib_q, nib_d;
    logic [3:0]           cmd_q, cmd_d;
    logic                 is_read_q, is_read_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           shift_q, shift_d;
    logic [3:0]           out_q, out_d;
    logic                 oe_q, oe_d;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            csn_s1_q  <= 1'b1;
            csn_s2_q  <= 1'b1;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            io_s1_q   <= 4'h0;
            io_s2_q   <= 4'h0;
        end else begin
            csn_s1_q  <= spi_csn;
            csn_s2_q  <= csn_s1_q;
            sclk_s1_q <= spi_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            io_s1_q   <= spi_io_in;
            io_s2_q   <= io_s1_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;

    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        cmd_d     = cmd_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        out_d     = out_q;
        oe_d      = oe_q;
        mem_we    = 1'b0;
        mem_wdata = {shift_q[3:0], io_s2_q};
        // Deselect outranks everything, including an SCLK edge seen in the same cycle.
        if (csn_s2_q) begin
            state_d = ST_IDLE;
            nib_d   = 3'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    nib_d   = 3'd0;
                end
                ST_CMD: if (sclk_rise) begin
                    cmd_d = io_s2_q;
                    nib_d = nib_q + 3'd1;
                    if (nib_q[0]) begin
                        nib_d = 3'd0;
                        if ({cmd_q, io_s2_q} == QSPI_CMD_READ) begin
                            is_read_d = 1'b1;
                            state_d   = ST_ADDR;
                        end else if ({cmd_q, io_s2_q} == QSPI_CMD_WRITE) begin
                            is_read_d = 1'b0;
                            state_d   = ST_ADDR;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: if (sclk_rise) begin
                    // Upper address bits fall off the top, giving the aliasing.
                    addr_d = {addr_q[ADDR_BITS-5:0], io_s2_q};
                    nib_d  = nib_q + 3'd1;
                    if (nib_q == 3'(ADDR_NIBBLES - 1)) begin
                        nib_d   = 3'd0;
                        state_d = is_read_q ? ST_DUMMY : ST_WDATA;
                    end
                end
                ST_DUMMY: if (sclk_rise) begin
                    nib_d = nib_q + 3'd1;
                    if (nib_q == 3'(DUMMY_CYCLES - 1)) begin
                        nib_d   = 3'd0;
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA: if (sclk_fall) begin
                    oe_d  = 1'b1;
                    nib_d = {2'b00, ~nib_q[0]};
                    if (!nib_q[0]) begin
                        // Latch the byte so the low nibble survives the prefetch of the next one.
                        out_d   = mem_rdata[7:4];
                        shift_d = mem_rdata;
                        addr_d  = addr_q + ADDR_ONE;
                    end else begin
                        out_d = shift_q[3:0];
                    end
                end
                ST_WDATA: if (sclk_rise) begin
                    nib_d = {2'b00, ~nib_q[0]};
                    if (!nib_q[0]) begin
                        shift_d = {4'h0, io_s2_q};
                    end else begin
                        mem_we = 1'b1;
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            nib_q     <= 3'd0;
            cmd_q     <= 4'h0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            shift_q   <= 8'h00;
            out_q     <= 4'h0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_q     <= nib_d;
            cmd_q     <= cmd_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
        end
    end

    // Reads track the next address so data is ready a cycle after any address change.
    assign mem_addr = mem_we ? addr_q : addr_d;

    qspi_ram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign spi_io_out = out_q;
    assign spi_io_oe  = {4{oe_q}};
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qspi_ram_target.sv
// Bench for qspi_ram_target: drives a QPI initiator at clk/8 and checks reads
// against a byte-array model of the RAM.
module tb_qspi_ram_target;

    localparam int MEM_BYTES = 1024;
    localparam int DUMMY     = 2;

    logic       clk;
    logic       rst;
    logic       spi_csn;
    logic       spi_sclk;
    logic [3:0] spi_io_in;
    logic [3:0] spi_io_out;
    logic [3:0] spi_io_oe;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] model [MEM_BYTES];
    logic [7:0] exp_q [$];
    logic [7:0] wbuf  [16];

    typedef struct {
        logic [23:0] waddr;
        logic [7:0]  wd0;
        logic [7:0]  wd1;
        logic [23:0] raddr;
        int          rlen;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    vec_t vecs [5];

    qspi_ram_target dut (
        .clk        (clk),
        .rst        (rst),
        .spi_csn    (spi_csn),
        .spi_sclk   (spi_sclk),
        .spi_io_in  (spi_io_in),
        .spi_io_out (spi_io_out),
        .spi_io_oe  (spi_io_oe),
        .busy       (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Driver tasks: one SCLK period is 8 clk; outputs are sampled just before the rise.
    task automatic sclk_pulse(input logic [3:0] nib, output logic [3:0] got_io, output logic [3:0] got_oe);
        spi_io_in = nib;
        repeat (4) @(negedge clk);
        got_io   = spi_io_out;
        got_oe   = spi_io_oe;
        spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_sclk = 1'b0;
        spi_csn  = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] d, o;
        sclk_pulse(b[7:4], d, o);
        sclk_pulse(b[3:0], d, o);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        send_byte(op);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic do_write(input logic [23:0] a, input int n);
        cs_low();
        send_hdr(8'h02, a);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i]);
            model[(int'(a[9:0]) + i) % MEM_BYTES] = wbuf[i];
        end
        cs_high();
    endtask

    // Scoreboard: every read byte is matched against the front of exp_q.
    task automatic do_read(input logic [23:0] a, input int n, input string tag);
        logic [3:0] hi, lo, oe_h, oe_l;
        logic [7:0] e;
        cs_low();
        send_hdr(8'h03, a);
        for (int i = 0; i < DUMMY; i++) sclk_pulse(4'($urandom), hi, oe_h);
        for (int i = 0; i < n; i++) begin
            sclk_pulse(4'($urandom), hi, oe_h);
            sclk_pulse(4'($urandom), lo, oe_l);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s: expected queue empty at byte %0d", tag, i);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s data[%0d]", tag, i), {24'h0, hi, lo}, {24'h0, e});
                check($sformatf("%s oe[%0d]", tag, i), {24'h0, oe_h, oe_l}, 32'hFF);
            end
        end
        cs_high();
    endtask

    task automatic expect_model(input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model[(int'(a[9:0]) + i) % MEM_BYTES]);
    endtask

    initial begin
        logic [3:0]  d, o;
        logic [23:0] a;
        logic [31:0] r;
        int          n, off, oe_seen;

        vecs[0] = '{24'h000010, 8'hA5, 8'h3C, 24'h000010, 2, 8'hA5, 8'h3C};
        vecs[1] = '{24'h0003FF, 8'h11, 8'h22, 24'h0003FF, 2, 8'h11, 8'h22};
        vecs[2] = '{24'h000100, 8'h5A, 8'hC3, 24'h000000, 1, 8'h22, 8'h00};
        vecs[3] = '{24'hABC123, 8'hDE, 8'hAD, 24'h000123, 2, 8'hDE, 8'hAD};
        vecs[4] = '{24'h000200, 8'h00, 8'hFF, 24'h000200, 2, 8'h00, 8'hFF};

        // Reset
        rst       = 1'b1;
        spi_csn   = 1'b1;
        spi_sclk  = 1'b0;
        spi_io_in = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset io_out", {28'h0, spi_io_out}, 32'h0);
        check("reset oe", {28'h0, spi_io_oe}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);

        // Table-driven write/read pairs
        for (int v = 0; v < 5; v++) begin
            wbuf[0] = vecs[v].wd0;
            wbuf[1] = vecs[v].wd1;
            do_write(vecs[v].waddr, 2);
            exp_q.push_back(vecs[v].e0);
            if (vecs[v].rlen > 1) exp_q.push_back(vecs[v].e1);
            do_read(vecs[v].raddr, vecs[v].rlen, $sformatf("vec%0d", v));
        end

        // Reset in the middle of a read
        cs_low();
        send_hdr(8'h03, 24'h000010);
        for (int i = 0; i < DUMMY; i++) sclk_pulse(4'h0, d, o);
        repeat (4) @(negedge clk);
        check("midread oe", {28'h0, spi_io_oe}, 32'hF);
        check("midread io", {28'h0, spi_io_out}, 32'hA);
        rst = 1'b1;
        @(negedge clk);
        check("rst oe", {28'h0, spi_io_oe}, 32'h0);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst io_out", {28'h0, spi_io_out}, 32'h0);
        spi_csn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post rst busy", {31'h0, busy}, 32'h0);
        expect_model(24'h000010, 2);
        do_read(24'h000010, 2, "post rst read");

        // Unknown opcode: nothing driven, nothing written
        wbuf[0] = 8'h77;
        do_write(24'h000040, 1);
        oe_seen = 0;
        cs_low();
        send_byte(8'h9F);
        r = 32'h00004012;
        for (int i = 0; i < 6; i++) begin
            sclk_pulse(4'h0, d, o);
            if (o != 4'h0) oe_seen++;
        end
        sclk_pulse(4'h1, d, o);
        if (o != 4'h0) oe_seen++;
        sclk_pulse(4'h2, d, o);
        if (o != 4'h0) oe_seen++;
        check("ignore oe count", oe_seen, 0);
        check("ignore busy", {31'h0, busy}, 32'h1);
        spi_sclk = 1'b0;
        spi_csn  = 1'b1;
        repeat (3) @(negedge clk);
        check("ignore busy drop", {31'h0, busy}, 32'h0);
        repeat (4) @(negedge clk);
        expect_model(24'h000040, 1);
        do_read(24'h000040, 1, "ignore no write");

        // Partial write discarded at deselect
        wbuf[0] = 8'h66;
        do_write(24'h000020, 1);
        cs_low();
        send_hdr(8'h02, 24'h000020);
        sclk_pulse(4'h7, d, o);
        cs_high();
        expect_model(24'h000020, 1);
        do_read(24'h000020, 1, "partial write");

        // Randomized bursts against the model; round 0 is a 16-byte burst across the wrap
        for (int k = 0; k < 6; k++) begin
            r = $urandom;
            if (k == 0) begin
                a = {r[13:0], 10'h3F8};
                n = 16;
            end else begin
                a = r[23:0];
                n = $urandom_range(1, 16);
            end
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n);
            expect_model(a, n);
            do_read(a, n, $sformatf("rand%0d", k));
            off = $urandom_range(0, n - 1);
            expect_model(a + 24'(off), n - off);
            do_read(a + 24'(off), n - off, $sformatf("rand%0d off", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
